simd_mem_arbiter: RTL and testbench

//  Shares the single SIMD memory port between N_REQ simd_fsm instances. Each unit raises o_req in

---
 rtl/simd_mem_arbiter_pkg.sv | 24 ++
 rtl/simd_mem_arbiter_rr_picker.sv | 47 ++++
 rtl/simd_mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_simd_mem_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simd_mem_arbiter_pkg.sv
// Shared definitions for the SIMD memory-port arbiter and the units that use it.
// The unit count lives here so the issuer and the arbiter always agree on it.
package simd_mem_arbiter_pkg;

    // Number of SIMD units sharing the memory port.
    localparam int SIMD_N_UNITS = 4;

    // Default number of cycles a grant may be held while others are waiting.
    localparam int ARB_MAX_HOLD = 16;

    // Width of a grant owner index for the default unit count.
    localparam int GNT_ID_W = $clog2(SIMD_N_UNITS);

    // Grant owner index for the default configuration.
    typedef logic [GNT_ID_W-1:0] gnt_id_t;

    // Arbiter control states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } arb_state_t;

endpackage : simd_mem_arbiter_pkg

// File: rtl/simd_mem_arbiter_rr_picker.sv
// Round-robin picker: rotates the request vector so that position 'ptr' becomes
// bit 0, priority-encodes the lowest set bit, and maps the offset back to an
// absolute unit index. Purely combinational.
module simd_mem_arbiter_rr_picker #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             found,
    output logic [ID_W-1:0]  idx
);

    // N_REQ expressed at the width of the ptr+offset sum, for the wrap step.
    localparam logic [ID_W:0] N_REQ_W = (ID_W+1)'(N_REQ);

    logic [2*N_REQ-1:0] dbl_s;
    logic [N_REQ-1:0]   rot_s;
    logic [ID_W-1:0]    off_s;
    logic [ID_W:0]      sum_s;
    logic [ID_W:0]      wrap_s;

    // Rotate, find the lowest set bit, then convert the offset to an absolute index.
    always_comb begin
        dbl_s  = {req, req} >> ptr;
        rot_s  = dbl_s[N_REQ-1:0];
        found  = 1'b0;
        off_s  = '0;
        // Scan high to low so the lowest set bit is the last one written.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot_s[i]) begin
                found = 1'b1;
                off_s = ID_W'(i);
            end else begin
                off_s = off_s;
            end
        end
        sum_s  = {1'b0, ptr} + {1'b0, off_s};
        wrap_s = sum_s - N_REQ_W;
        if (sum_s >= N_REQ_W) begin
            idx = wrap_s[ID_W-1:0];
        end else begin
            idx = sum_s[ID_W-1:0];
        end
    end

endmodule : simd_mem_arbiter_rr_picker

// File: rtl/simd_mem_arbiter.sv
// Round-robin arbiter for the single SIMD memory port. A grant is held while
// its owner keeps requesting, is pre-empted after MAX_HOLD cycles when another
// unit waits, is never removed while memory is busy, and is always followed by
// one dead S_GAP turnaround cycle before the next arbitration.
module simd_mem_arbiter
    import simd_mem_arbiter_pkg::*;
#(
    parameter int N_REQ    = SIMD_N_UNITS,
    parameter int MAX_HOLD = ARB_MAX_HOLD,
    parameter int ID_W     = $clog2(N_REQ)
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_en,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_mem_busy,
    output logic [N_REQ-1:0] o_grant,
    output logic             o_gnt_valid,
    output logic [ID_W-1:0]  o_gnt_id,
    output logic             o_preempt
);

    localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
    localparam logic [ID_W-1:0]   ID_LAST  = ID_W'(N_REQ - 1);
    localparam logic [ID_W-1:0]   ID_ONE   = ID_W'(1);
    localparam logic [N_REQ-1:0]  GNT_ONE  = N_REQ'(1);

    arb_state_t        state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic              gnt_valid_q, gnt_valid_d;
    logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
    logic              preempt_q, preempt_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    logic              pick_found_s;
    logic [ID_W-1:0]   pick_idx_s;
    logic              owner_req_s;
    logic              others_s;
    logic              expired_s;
    logic [HOLD_W-1:0] hold_inc_s;

    simd_mem_arbiter_rr_picker #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_picker (
        .req   (i_req),
        .ptr   (rr_ptr_q),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    // Grant bookkeeping shared by the state machine.
    always_comb begin
        owner_req_s = i_req[gnt_id_q];
        others_s    = |(i_req & ~grant_q);
        expired_s   = (hold_cnt_q == HOLD_MAX);
        if (expired_s) begin
            hold_inc_s = hold_cnt_q;
        end else begin
            hold_inc_s = hold_cnt_q + HOLD_ONE;
        end
    end

    // Next-state and next-output logic for the arbitration FSM.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gnt_id_d   = gnt_id_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        preempt_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Only the live request level is considered; nothing is latched.
                if (i_en && pick_found_s) begin
                    grant_d    = GNT_ONE << pick_idx_s;
                    gnt_id_d   = pick_idx_s;
                    hold_cnt_d = '0;
                    state_d    = S_GRANT;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_GRANT: begin
                if (i_mem_busy) begin
                    // Memory mid-transaction: the grant is frozen.
                    hold_cnt_d = hold_inc_s;
                end else if (!owner_req_s) begin
                    // Voluntary release wins over a simultaneous expiry.
                    grant_d = '0;
                    state_d = S_GAP;
                end else if (expired_s && others_s) begin
                    grant_d   = '0;
                    preempt_d = 1'b1;
                    state_d   = S_GAP;
                end else begin
                    hold_cnt_d = hold_inc_s;
                end
            end

            S_GAP: begin
                // Next search starts just past the unit that was served.
                if (gnt_id_q == ID_LAST) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = gnt_id_q + ID_ONE;
                end
                hold_cnt_d = '0;
                state_d    = S_IDLE;
            end

            default: begin
                grant_d    = '0;
                hold_cnt_d = '0;
                state_d    = S_IDLE;
            end
        endcase

        gnt_valid_d = |grant_d;
    end

    // State and registered outputs; reset drops any grant immediately.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            preempt_q   <= 1'b0;
            rr_ptr_q    <= '0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
            preempt_q   <= preempt_d;
            rr_ptr_q    <= rr_ptr_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign o_grant     = grant_q;
    assign o_gnt_valid = gnt_valid_q;
    assign o_gnt_id    = gnt_id_q;
    assign o_preempt   = preempt_q;

endmodule : simd_mem_arbiter

// File: tb/tb_simd_mem_arbiter.sv
// Directed bench for simd_mem_arbiter (N_REQ=4, MAX_HOLD=16).
module tb_simd_mem_arbiter;

    logic       i_clk;
    logic       i_rstn;
    logic       i_en;
    logic [3:0] i_req;
    logic       i_mem_busy;
    logic [3:0] o_grant;
    logic       o_gnt_valid;
    logic [1:0] o_gnt_id;
    logic       o_preempt;

    int total = 0;
    int bad   = 0;

    simd_mem_arbiter #(
        .N_REQ    (4),
        .MAX_HOLD (16),
        .ID_W     (2)
    ) dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_en        (i_en),
        .i_req       (i_req),
        .i_mem_busy  (i_mem_busy),
        .o_grant     (o_grant),
        .o_gnt_valid (o_gnt_valid),
        .o_gnt_id    (o_gnt_id),
        .o_preempt   (o_preempt)
    );

    // 10 ns clock.
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Advance one clock; outputs are sampled and inputs driven 1 ns after the edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Put the DUT back into a known state with all inputs quiet.
    task automatic do_reset();
        i_rstn     = 1'b0;
        i_en       = 1'b0;
        i_req      = 4'b0000;
        i_mem_busy = 1'b0;
        step();
        step();
        i_rstn = 1'b1;
    endtask

    task automatic test_reset();
        i_rstn     = 1'b0;
        i_en       = 1'b1;
        i_req      = 4'b1111;
        i_mem_busy = 1'b0;
        step();
        total++;
        if ({o_grant, o_gnt_valid, o_gnt_id, o_preempt} !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs got grant=%b valid=%b id=%0d pre=%b want all 0",
                     o_grant, o_gnt_valid, o_gnt_id, o_preempt);
        end
        i_req  = 4'b0000;
        i_rstn = 1'b1;
        step();
        total++;
        if (o_grant !== 4'b0000) begin
            bad++;
            $display("FAIL idle_no_req got grant=%b want 0000", o_grant);
        end
    endtask

    task automatic test_single();
        do_reset();
        i_en  = 1'b1;
        i_req = 4'b0100;
        step();
        total++;
        if (o_grant !== 4'b0100 || o_gnt_id !== 2'd2 || o_gnt_valid !== 1'b1) begin
            bad++;
            $display("FAIL single_grant got grant=%b id=%0d valid=%b want 0100 2 1",
                     o_grant, o_gnt_id, o_gnt_valid);
        end
    endtask

    task automatic test_rotation();
        int         seq [5] = '{0, 1, 2, 3, 0};
        logic [3:0] exp_g;
        do_reset();
        i_en  = 1'b1;
        i_req = 4'b1111;
        step();
        for (int o = 0; o < 5; o++) begin
            exp_g = 4'b0001 << seq[o];
            for (int c = 0; c < 16; c++) begin
                total++;
                if (o_grant !== exp_g || o_gnt_id !== 2'(seq[o]) || o_preempt !== 1'b0) begin
                    bad++;
                    $display("FAIL rot_hold o=%0d c=%0d got grant=%b id=%0d pre=%b want %b %0d 0",
                             o, c, o_grant, o_gnt_id, o_preempt, exp_g, seq[o]);
                end
                step();
            end
            total++;
            if (o_grant !== 4'b0000 || o_preempt !== 1'b1) begin
                bad++;
                $display("FAIL rot_preempt o=%0d got grant=%b pre=%b want 0000 1",
                         o, o_grant, o_preempt);
            end
            if (o < 4) begin
                step();
                total++;
                if (o_grant !== 4'b0000 || o_preempt !== 1'b0) begin
                    bad++;
                    $display("FAIL rot_idle o=%0d got grant=%b pre=%b want 0000 0",
                             o, o_grant, o_preempt);
                end
                step();
            end
        end
        i_req = 4'b0000;
    endtask

    task automatic test_sole_owner();
        do_reset();
        i_en  = 1'b1;
        i_req = 4'b0010;
        step();
        for (int c = 0; c < 40; c++) begin
            total++;
            if (o_grant !== 4'b0010 || o_preempt !== 1'b0) begin
                bad++;
                $display("FAIL sole_hold c=%0d got grant=%b pre=%b want 0010 0",
                         c, o_grant, o_preempt);
            end
            step();
        end
        i_req = 4'b0000;
        step();
        total++;
        if (o_grant !== 4'b0000 || o_preempt !== 1'b0 || o_gnt_id !== 2'd1) begin
            bad++;
            $display("FAIL sole_release got grant=%b pre=%b id=%0d want 0000 0 1",
                     o_grant, o_preempt, o_gnt_id);
        end
        // Units 0,1,3 request; a pointer at 2 must pick unit 3.
        i_req = 4'b1011;
        step();
        total++;
        if (o_grant !== 4'b0000) begin
            bad++;
            $display("FAIL sole_gap got grant=%b want 0000", o_grant);
        end
        step();
        total++;
        if (o_grant !== 4'b1000 || o_gnt_id !== 2'd3) begin
            bad++;
            $display("FAIL sole_ptr got grant=%b id=%0d want 1000 3", o_grant, o_gnt_id);
        end
        i_req = 4'b0000;
    endtask

    task automatic test_busy_hold();
        do_reset();
        i_en  = 1'b1;
        i_req = 4'b0001;
        step();
        i_req = 4'b1001;
        for (int c = 0; c < 15; c++) begin
            step();
        end
        i_mem_busy = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            total++;
            if (o_grant !== 4'b0001 || o_preempt !== 1'b0) begin
                bad++;
                $display("FAIL busy_hold c=%0d got grant=%b pre=%b want 0001 0",
                         c, o_grant, o_preempt);
            end
        end
        i_mem_busy = 1'b0;
        step();
        total++;
        if (o_grant !== 4'b0000 || o_preempt !== 1'b1) begin
            bad++;
            $display("FAIL busy_fall got grant=%b pre=%b want 0000 1", o_grant, o_preempt);
        end
        step();
        total++;
        if (o_grant !== 4'b0000) begin
            bad++;
            $display("FAIL busy_gap got grant=%b want 0000", o_grant);
        end
        step();
        total++;
        if (o_grant !== 4'b1000 || o_gnt_id !== 2'd3) begin
            bad++;
            $display("FAIL busy_next got grant=%b id=%0d want 1000 3", o_grant, o_gnt_id);
        end
        i_req = 4'b0000;
    endtask

    task automatic test_release_at_expiry();
        do_reset();
        i_en  = 1'b1;
        i_req = 4'b0011;
        step();
        for (int c = 0; c < 15; c++) begin
            step();
        end
        i_req = 4'b0010;
        step();
        total++;
        if (o_grant !== 4'b0000 || o_preempt !== 1'b0) begin
            bad++;
            $display("FAIL rel_expiry got grant=%b pre=%b want 0000 0", o_grant, o_preempt);
        end
        step();
        step();
        total++;
        if (o_grant !== 4'b0010 || o_gnt_id !== 2'd1) begin
            bad++;
            $display("FAIL rel_next got grant=%b id=%0d want 0010 1", o_grant, o_gnt_id);
        end
        i_req = 4'b0000;
    endtask

    task automatic test_enable_gate();
        do_reset();
        i_en  = 1'b1;
        i_req = 4'b0001;
        step();
        i_en  = 1'b0;
        i_req = 4'b0011;
        for (int c = 0; c < 3; c++) begin
            step();
            total++;
            if (o_grant !== 4'b0001) begin
                bad++;
                $display("FAIL en_keep c=%0d got grant=%b want 0001", c, o_grant);
            end
        end
        i_req = 4'b0010;
        for (int c = 0; c < 6; c++) begin
            step();
            total++;
            if (o_grant !== 4'b0000 || o_gnt_valid !== 1'b0 || o_gnt_id !== 2'd0) begin
                bad++;
                $display("FAIL en_block c=%0d got grant=%b valid=%b id=%0d want 0000 0 0",
                         c, o_grant, o_gnt_valid, o_gnt_id);
            end
        end
        i_en = 1'b1;
        step();
        total++;
        if (o_grant !== 4'b0010 || o_gnt_id !== 2'd1) begin
            bad++;
            $display("FAIL en_resume got grant=%b id=%0d want 0010 1", o_grant, o_gnt_id);
        end
        i_req = 4'b0000;
    endtask

    task automatic test_async_reset();
        do_reset();
        i_en  = 1'b1;
        i_req = 4'b0100;
        step();
        i_req = 4'b0000;
        step();
        step();
        // Pointer now sits at 3; a fresh grant to unit 2 wraps around.
        i_req = 4'b0100;
        step();
        step();
        total++;
        if (o_grant !== 4'b0100) begin
            bad++;
            $display("FAIL ar_pre got grant=%b want 0100", o_grant);
        end
        #3;
        i_rstn = 1'b0;
        #1;
        total++;
        if (o_grant !== 4'b0000 || o_gnt_valid !== 1'b0 || o_gnt_id !== 2'd0) begin
            bad++;
            $display("FAIL ar_drop got grant=%b valid=%b id=%0d want 0000 0 0",
                     o_grant, o_gnt_valid, o_gnt_id);
        end
        step();
        i_rstn = 1'b1;
        i_req  = 4'b1010;
        step();
        total++;
        if (o_grant !== 4'b0010 || o_gnt_id !== 2'd1) begin
            bad++;
            $display("FAIL ar_ptr got grant=%b id=%0d want 0010 1", o_grant, o_gnt_id);
        end
        i_req = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_sole_owner();
        test_busy_hold();
        test_release_at_expiry();
        test_enable_gate();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule : tb_simd_mem_arbiter
